// File: rtl/exec_writeback.sv
// rtl/exec_writeback.sv - minicpu execute/writeback stage with RUN/HALT sequencer
//
// Adds the selected operand to the instruction immediate and writes the sum
// into any combination of A, B, OUT and PC. Holds the architectural state and
// stops the core on a jump-to-self until resumed.
//
// Optional feature macro: MINICPU_RETIRE_CNT_EN (adds 16-bit retired counter).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   step      in   instruction strobe
//   resume    in   leave HALT on the next step
//   alu_in    in   [DW] operand from the data selector
//   imm       in   [DW] instruction immediate
//   ld_a      in   write sum into reg_a
//   ld_b      in   write sum into reg_b
//   ld_out    in   write sum into out_port
//   ld_pc     in   write sum into pc, else pc increments
//   reg_a     out  [DW] register A
//   reg_b     out  [DW] register B
//   out_port  out  [DW] output port register
//   pc        out  [PW] program counter
//   carry     out  carry flag of the last executed add
//   halted    out  high while in HALT
//   retired   out  [16] executed-instruction count (MINICPU_RETIRE_CNT_EN only)
module exec_writeback #(
    parameter int DW = 4,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          resume,
    input  logic [DW-1:0] alu_in,
    input  logic [DW-1:0] imm,
    input  logic          ld_a,
    input  logic          ld_b,
    input  logic          ld_out,
    input  logic          ld_pc,
    output logic [DW-1:0] reg_a,
    output logic [DW-1:0] reg_b,
    output logic [DW-1:0] out_port,
    output logic [PW-1:0] pc,
    output logic          carry,
    output logic          halted
`ifdef MINICPU_RETIRE_CNT_EN
    ,
    output logic [15:0]   retired
`endif
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [DW-1:0] res;
    logic          cout;
    logic [PW-1:0] res_pc;
    logic          exec_en;
    logic          resume_en;

    always_comb begin
        {cout, res} = {1'b0, alu_in} + {1'b0, imm};
        res_pc      = PW'(res);
    end

    // Sequencer: executed cycles only happen in RUN; a jump whose target is
    // the current pc parks the core in HALT after that instruction commits.
    always_comb begin
        state_next = state;
        exec_en    = 1'b0;
        resume_en  = 1'b0;
        case (state)
            ST_RUN: begin
                if (step) begin
                    exec_en = 1'b1;
                    if (ld_pc && (res_pc == pc)) begin
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (step && resume) begin
                    resume_en  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    assign halted = (state == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a    <= '0;
            reg_b    <= '0;
            out_port <= '0;
            pc       <= '0;
            carry    <= 1'b0;
        end else if (exec_en) begin
            carry <= cout;
            if (ld_a)   reg_a    <= res;
            if (ld_b)   reg_b    <= res;
            if (ld_out) out_port <= res;
            pc <= ld_pc ? res_pc : pc + 1'b1;
        end else if (resume_en) begin
            // Step past the self-loop so execution continues after it.
            pc <= pc + 1'b1;
        end
    end

`ifdef MINICPU_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (exec_en) begin
            retired <= retired + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exec_writeback.sv
// tb/tb_exec_writeback.sv - directed self-checking bench for exec_writeback
module tb_exec_writeback;

    logic       clk = 1'b0;
    logic       rst;
    logic       step;
    logic       resume;
    logic [3:0] alu_in;
    logic [3:0] imm;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       ld_pc;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] out_port;
    logic [3:0] pc;
    logic       carry;
    logic       halted;
`ifdef MINICPU_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    int total = 0;
    int bad   = 0;

    exec_writeback #(.DW(4), .PW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .resume   (resume),
        .alu_in   (alu_in),
        .imm      (imm),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .ld_out   (ld_out),
        .ld_pc    (ld_pc),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .out_port (out_port),
        .pc       (pc),
        .carry    (carry),
        .halted   (halted)
`ifdef MINICPU_RETIRE_CNT_EN
        ,
        .retired  (retired)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, clock it, and settle 1 time unit past the edge.
    task automatic cyc(input logic s, input logic r, input logic [3:0] a, input logic [3:0] i,
                       input logic la, input logic lb, input logic lo, input logic lp);
        step   = s;
        resume = r;
        alu_in = a;
        imm    = i;
        ld_a   = la;
        ld_b   = lb;
        ld_out = lo;
        ld_pc  = lp;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                             input logic [3:0] eo, input logic [3:0] ep, input logic ec,
                             input logic eh);
        check({tag, ".reg_a"},    16'(reg_a),    16'(ea));
        check({tag, ".reg_b"},    16'(reg_b),    16'(eb));
        check({tag, ".out_port"}, 16'(out_port), 16'(eo));
        check({tag, ".pc"},       16'(pc),       16'(ep));
        check({tag, ".carry"},    16'(carry),    16'(ec));
        check({tag, ".halted"},   16'(halted),   16'(eh));
    endtask

    initial begin
        rst = 1'b1;
        cyc(0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        cyc(0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        rst = 1'b0;
        check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef MINICPU_RETIRE_CNT_EN
        check("reset.retired", retired, 16'd0);
`endif

        // 3 + 4 into A
        cyc(1, 0, 4'h3, 4'h4, 1, 0, 0, 0);
        check_all("add_a", 4'h7, 4'h0, 4'h0, 4'h1, 1'b0, 1'b0);

        // F + 2 overflows into B and OUT together
        cyc(1, 0, 4'hF, 4'h2, 0, 1, 1, 0);
        check_all("carry_set", 4'h7, 4'h1, 4'h1, 4'h2, 1'b1, 1'b0);

        // no-load instruction still rewrites carry
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        check_all("carry_clr", 4'h7, 4'h1, 4'h1, 4'h3, 1'b0, 1'b0);

        // jump to 0xF, then increment wraps to 0
        cyc(1, 0, 4'h0, 4'hF, 0, 0, 0, 1);
        check_all("jmp_f", 4'h7, 4'h1, 4'h1, 4'hF, 1'b0, 1'b0);
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        check_all("pc_wrap", 4'h7, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0);
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        check("pc_2", 16'(pc), 16'h2);

        // ordinary jump 2 -> 9
        cyc(1, 0, 4'h0, 4'h9, 0, 0, 0, 1);
        check_all("jmp_9", 4'h7, 4'h1, 4'h1, 4'h9, 1'b0, 1'b0);

        // jump 9 -> 5, then jump-to-self at 5 while also loading A
        cyc(1, 0, 4'h0, 4'h5, 0, 0, 0, 1);
        check_all("jmp_5", 4'h7, 4'h1, 4'h1, 4'h5, 1'b0, 1'b0);
        cyc(1, 0, 4'h0, 4'h5, 1, 0, 0, 1);
        check_all("halt_enter", 4'h5, 4'h1, 4'h1, 4'h5, 1'b0, 1'b1);

        // in HALT, steps and loads are ignored; resume without step too
        cyc(1, 0, 4'h1, 4'h1, 1, 1, 1, 0);
        check_all("halt_step", 4'h5, 4'h1, 4'h1, 4'h5, 1'b0, 1'b1);
        cyc(0, 1, 4'h1, 4'h1, 1, 0, 0, 0);
        check_all("halt_resume_nostep", 4'h5, 4'h1, 4'h1, 4'h5, 1'b0, 1'b1);

        // step + resume leaves HALT, pc moves past the loop, no writes
        cyc(1, 1, 4'h2, 4'hF, 1, 1, 1, 0);
        check_all("resume", 4'h5, 4'h1, 4'h1, 4'h6, 1'b0, 1'b0);

        // resume in RUN is just an ordinary instruction
        cyc(1, 1, 4'h4, 4'h4, 0, 1, 0, 0);
        check_all("resume_in_run", 4'h5, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0);

        // idle cycles with loads toggling change nothing
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 4'(k), 4'hC, k[0], k[1], ~k[0], k[2]);
            check_all($sformatf("idle%0d", k), 4'h5, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0);
        end

        // load A = 0xA, then reset on the same edge as another load
        cyc(1, 0, 4'h0, 4'hA, 1, 0, 0, 0);
        check_all("load_a_a", 4'hA, 4'h8, 4'h1, 4'h8, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1, 0, 4'hF, 4'hF, 1, 1, 1, 1);
        rst = 1'b0;
        check_all("rst_over_step", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
`ifdef MINICPU_RETIRE_CNT_EN
        check("rst.retired", retired, 16'd0);
`endif

        // two steps, jump-to-self at pc 2 (third executed), then two ignored steps
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        cyc(1, 0, 4'h1, 4'h1, 0, 0, 0, 1);
        check_all("halt2", 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b1);
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        cyc(1, 0, 4'h0, 4'h0, 0, 0, 0, 0);
`ifdef MINICPU_RETIRE_CNT_EN
        check("retired3", retired, 16'd3);
`endif
        cyc(1, 1, 4'h0, 4'h0, 0, 0, 0, 0);
        check_all("resume2", 4'h0, 4'h0, 4'h0, 4'h3, 1'b0, 1'b0);
`ifdef MINICPU_RETIRE_CNT_EN
        check("retired_resume", retired, 16'd3);
`endif

        // reset while halted returns to RUN
        cyc(1, 0, 4'h0, 4'h3, 0, 0, 0, 1);
        check("halt3", 16'(halted), 16'h1);
        rst = 1'b1;
        cyc(0, 0, 4'h0, 4'h0, 0, 0, 0, 0);
        rst = 1'b0;
        check_all("rst_in_halt", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/exec_writeback.md
Name: exec_writeback

Overview:
- Downstream neighbour of the 4-bit operand data selector in the minicpu datapath.
- Takes the selected operand (register A, register B, input port or zero), adds the instruction's 4-bit immediate, and writes the sum into A, B, the output port or the PC.
- Holds the architectural state (A, B, OUT, PC, carry flag).
- Runs a small RUN/HALT sequencer that stops the core on a jump-to-self.

Parameters:
- DW, 4, datapath width of A, B, OUT, operand and immediate.
- PW, 4, program counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- step  input  1  instruction strobe; one instruction executes per cycle with step=1.
- resume  input  1  leaves HALT at the next step.
- alu_in  input  DW  operand from data selector output.
- imm  input  DW  immediate field of current instruction.
- ld_a  input  1  write sum into reg_a.
- ld_b  input  1  write sum into reg_b.
- ld_out  input  1  write sum into out_port.
- ld_pc  input  1  write sum into pc (jump); otherwise pc increments.
- reg_a  output  DW  register A (fed back to selector c0).
- reg_b  output  DW  register B (fed back to selector c1).
- out_port  output  DW  output port register.
- pc  output  PW  program counter (instruction ROM address).
- carry  output  1  carry flag (consumed by decoder for JNC).
- halted  output  1  high in HALT state.

Behaviour:
- Reset (rst=1 at clk edge): reg_a, reg_b, out_port, pc, carry, halted all 0; state RUN. Reset wins over all other inputs, including mid-instruction and in HALT.
- Sum: {cout, res} = alu_in + imm as DW+1 bits; res = low DW bits.
- Executed cycle = step=1 and state RUN. In a non-executed cycle, all registers hold.
- Executed cycle updates, visible the cycle after the edge:
  - carry <= cout on every executed instruction, including non-add loads where cout=0.
  - reg_a <= res if ld_a; reg_b <= res if ld_b; out_port <= res if ld_out.
  - Multiple ld_* asserted together: all selected destinations written with the same res.
  - pc <= res (zero-extended/truncated to PW) if ld_pc; else pc <= pc+1.
  - pc increment wraps from 2^PW-1 to 0 with no flag.
- Latency: one cycle from the step edge to updated outputs. No combinational path from inputs to outputs.
- State machine, RUN -> HALT: executed cycle with ld_pc=1 and res == current pc (jump-to-self).
  - That cycle still commits: carry, pc (unchanged value), and any other ld_* writes.
  - halted=1 from the next cycle.
- State machine, HALT -> RUN: step=1 and resume=1 on the same edge.
  - That edge performs no execution; pc <= pc+1 so the core continues after the loop.
  - halted=0 the next cycle.
- In HALT: step alone does nothing; all registers hold; ld_* ignored.
- resume is ignored in RUN.

Optional Feature:
- Macro MINICPU_RETIRE_CNT_EN.
- Defined: adds output port retired (16 bits), reset 0, incremented on each executed cycle, wraps at 0xFFFF -> 0. Not incremented in HALT or on the resume edge.
- Undefined: port and counter absent; the rest of the behaviour is identical.

Test Plan:
- Reset then step with alu_in=0x3, imm=0x4, ld_a=1 -> reg_a=0x7, carry=0, pc=0x1 next cycle; all else 0.
- alu_in=0xF, imm=0x2, ld_b=1, ld_out=1 -> reg_b=0x1, out_port=0x1, carry=1. The next step with alu_in=0x0, imm=0x0, no ld -> carry=0.
- pc=0xF, step with no ld_pc -> pc=0x0. pc=0x2, ld_pc=1 with alu_in=0, imm=0x9 -> pc=0x9, halted stays 0.
- pc=0x5, ld_pc=1 with alu_in=0, imm=0x5 -> halted=1 next cycle, pc=0x5.
  - Subsequent steps with ld_a=1 leave reg_a unchanged.
  - step+resume -> halted=0, pc=0x6, no register writes.
- rst=1 asserted on the same edge as step with ld_a=1 while reg_a=0xA -> all outputs 0, halted=0.
- step=0 for 10 cycles with ld_* toggling -> no register changes. With MINICPU_RETIRE_CNT_EN: 3 executed steps then HALT plus 2 steps -> retired=3.
